// File: rtl/pa_core_csr_unit.sv
// pa_core_csr_unit: machine-mode CSR file with trap/mret updates, interrupt prioritisation and cycle/instret counters
module pa_core_csr_unit #(
    parameter int CNT_WIDTH     = 64,
    parameter int NUM_LOCAL_IRQ = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [11:0]              csr_raddr_i,
    output logic [31:0]              csr_rdata_o,
    input  logic [11:0]              csr_waddr_i,
    input  logic                     csr_wen_i,
    input  logic [1:0]               csr_wop_i,
    input  logic [31:0]              csr_wdata_i,
    input  logic                     instr_retire_i,
    input  logic                     trap_vld_i,
    input  logic [31:0]              trap_cause_i,
    input  logic [31:0]              trap_pc_i,
    input  logic [31:0]              trap_tval_i,
    input  logic                     mret_i,
    input  logic                     irq_sw_i,
    input  logic                     irq_tmr_i,
    input  logic                     irq_ext_i,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
    output logic                     irq_req_o,
    output logic [31:0]              irq_cause_o,
    output logic [31:0]              trap_target_o,
    output logic [31:0]              csr_mtvec_o,
    output logic [31:0]              csr_mepc_o,
    output logic [31:0]              csr_mstatus_o
);
    localparam logic [31:0] MIE_MASK = 32'(((1 << NUM_LOCAL_IRQ) - 1) << 16) | 32'h0000_0888;

    logic                 st_mie, st_mpie, cy_q, ir_q;
    logic [31:0]          mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [CNT_WIDTH-1:0] mcycle_q, minstret_q;
    logic [31:0]          mstatus, mip_d, pend, wold, wres;
    logic [4:0]           code;
    logic                 wr_en;

    assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mip_d   = (32'(irq_local_i) << 16) | {20'b0, irq_ext_i, 3'b0, irq_tmr_i, 3'b0, irq_sw_i, 3'b0};

    function automatic logic [31:0] csr_read(input logic [11:0] a);
        case (a)
            12'h300: csr_read = mstatus;
            12'h304: csr_read = mie_q;
            12'h305: csr_read = mtvec_q;
            12'h320: csr_read = {29'b0, ir_q, 1'b0, cy_q};
            12'h340: csr_read = mscratch_q;
            12'h341: csr_read = mepc_q;
            12'h342: csr_read = mcause_q;
            12'h343: csr_read = mtval_q;
            12'h344: csr_read = mip_q;
            12'hB00, 12'hC00: csr_read = mcycle_q[31:0];
            12'hB80, 12'hC80: csr_read = 32'(mcycle_q >> 32);
            12'hB02, 12'hC02: csr_read = minstret_q[31:0];
            12'hB82, 12'hC82: csr_read = 32'(minstret_q >> 32);
            default: csr_read = 32'b0;
        endcase
    endfunction

    assign csr_rdata_o = csr_read(csr_raddr_i);
    assign wold        = csr_read(csr_waddr_i);
    assign wr_en       = csr_wen_i && csr_wop_i != 2'b11;
    assign wres        = csr_wop_i == 2'b00 ? csr_wdata_i :
                         csr_wop_i == 2'b01 ? (wold | csr_wdata_i) : (wold & ~csr_wdata_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            cy_q       <= 1'b0;
            ir_q       <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mip_q <= mip_d & MIE_MASK;
            // trap and mret own mstatus/mepc/mcause/mtval in their cycle
            if (trap_vld_i) begin
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                mepc_q   <= trap_pc_i & ~32'h3;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_tval_i;
            end else if (mret_i) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr_en) begin
                case (csr_waddr_i)
                    12'h300: begin
                        st_mie  <= wres[3];
                        st_mpie <= wres[7];
                    end
                    12'h341: mepc_q   <= wres & ~32'h3;
                    12'h342: mcause_q <= wres;
                    12'h343: mtval_q  <= wres;
                    default: ;
                endcase
            end
            if (wr_en) begin
                case (csr_waddr_i)
                    12'h304: mie_q      <= wres & MIE_MASK;
                    12'h305: mtvec_q    <= wres & 32'hFFFF_FFFD;
                    12'h320: {ir_q, cy_q} <= {wres[2], wres[0]};
                    12'h340: mscratch_q <= wres;
                    default: ;
                endcase
            end
            if (wr_en && csr_waddr_i == 12'hB00)
                mcycle_q <= {mcycle_q[CNT_WIDTH-1:32], wres};
            else if (wr_en && csr_waddr_i == 12'hB80)
                mcycle_q <= {wres[CNT_WIDTH-33:0], mcycle_q[31:0]};
            else if (!cy_q)
                mcycle_q <= mcycle_q + CNT_WIDTH'(1);
            if (wr_en && csr_waddr_i == 12'hB02)
                minstret_q <= {minstret_q[CNT_WIDTH-1:32], wres};
            else if (wr_en && csr_waddr_i == 12'hB82)
                minstret_q <= {wres[CNT_WIDTH-33:0], minstret_q[31:0]};
            else if (instr_retire_i && !ir_q)
                minstret_q <= minstret_q + CNT_WIDTH'(1);
        end
    end

    assign pend = mip_q & mie_q;

    // later assignments win, so lower-priority sources are tested first
    always_comb begin
        code = 5'd0;
        if (pend[7])  code = 5'd7;
        if (pend[3])  code = 5'd3;
        if (pend[11]) code = 5'd11;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
            if (pend[16+i]) code = 5'(16 + i);
    end

    assign irq_req_o     = st_mie && |pend;
    assign irq_cause_o   = irq_req_o ? {1'b1, 26'b0, code} : 32'b0;
    assign trap_target_o = (mtvec_q[0] && trap_cause_i[31]) ?
                           {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause_i[4:0], 2'b00} :
                           {mtvec_q[31:2], 2'b00};
    assign csr_mtvec_o   = mtvec_q;
    assign csr_mepc_o    = mepc_q;
    assign csr_mstatus_o = mstatus;
endmodule

// File: tb/tb_pa_core_csr_unit.sv
// tb_pa_core_csr_unit: directed checks of CSR ops, trap/mret, vectoring, interrupt priority and counters
module tb_pa_core_csr_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;
    logic [11:0] csr_waddr_i = '0;
    logic        csr_wen_i = 1'b0;
    logic [1:0]  csr_wop_i = 2'b11;
    logic [31:0] csr_wdata_i = '0;
    logic        instr_retire_i = 1'b0;
    logic        trap_vld_i = 1'b0;
    logic [31:0] trap_cause_i = '0;
    logic [31:0] trap_pc_i = '0;
    logic [31:0] trap_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        irq_sw_i = 1'b0;
    logic        irq_tmr_i = 1'b0;
    logic        irq_ext_i = 1'b0;
    logic [3:0]  irq_local_i = '0;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic [31:0] trap_target_o;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] r, held;

    pa_core_csr_unit #(.CNT_WIDTH(40), .NUM_LOCAL_IRQ(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
        .csr_waddr_i(csr_waddr_i), .csr_wen_i(csr_wen_i), .csr_wop_i(csr_wop_i), .csr_wdata_i(csr_wdata_i),
        .instr_retire_i(instr_retire_i),
        .trap_vld_i(trap_vld_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
        .mret_i(mret_i),
        .irq_sw_i(irq_sw_i), .irq_tmr_i(irq_tmr_i), .irq_ext_i(irq_ext_i), .irq_local_i(irq_local_i),
        .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .trap_target_o(trap_target_o),
        .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_waddr_i = a;
        csr_wop_i   = op;
        csr_wdata_i = d;
        csr_wen_i   = 1'b1;
        tick();
        csr_wen_i   = 1'b0;
        csr_wop_i   = 2'b11;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_raddr_i = a;
        #1;
        d = csr_rdata_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rd(12'h300, r);
        n_cmp++; if (r !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus got %h want %h", r, 32'h1800); end
        n_cmp++; if (csr_mstatus_o !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus_o got %h want %h", csr_mstatus_o, 32'h1800); end
        n_cmp++; if (csr_mtvec_o !== 32'h0) begin n_fail++; $display("FAIL reset_mtvec got %h want 0", csr_mtvec_o); end
        n_cmp++; if (csr_mepc_o !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got %h want 0", csr_mepc_o); end
        rd(12'h304, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mie got %h want 0", r); end
        rd(12'hB00, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle got %h want 0", r); end
        rd(12'hB02, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_minstret got %h want 0", r); end
        n_cmp++; if (irq_req_o !== 1'b0 || irq_cause_o !== 32'h0) begin n_fail++; $display("FAIL reset_irq got %b/%h want 0/0", irq_req_o, irq_cause_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_set_clear();
        wr(12'h340, 2'b00, 32'hF0F0_0000);
        wr(12'h340, 2'b01, 32'h0000_000F);
        rd(12'h340, r);
        n_cmp++; if (r !== 32'hF0F0_000F) begin n_fail++; $display("FAIL set_op got %h want %h", r, 32'hF0F0_000F); end
        wr(12'h340, 2'b10, 32'hF000_0000);
        rd(12'h340, r);
        n_cmp++; if (r !== 32'h00F0_000F) begin n_fail++; $display("FAIL clear_op got %h want %h", r, 32'h00F0_000F); end
        wr(12'h340, 2'b11, 32'h1234_5678);
        rd(12'h340, r);
        n_cmp++; if (r !== 32'h00F0_000F) begin n_fail++; $display("FAIL nowrite_op got %h want %h", r, 32'h00F0_000F); end
        wr(12'h300, 2'b00, 32'hFFFF_FFFF);
        rd(12'h300, r);
        n_cmp++; if (r !== 32'h1888) begin n_fail++; $display("FAIL mstatus_mask got %h want %h", r, 32'h1888); end
        rd(12'h7C0, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", r); end
    endtask

    task automatic test_trap_mret();
        trap_vld_i   = 1'b1;
        trap_pc_i    = 32'h8000_0103;
        trap_cause_i = 32'h8000_0007;
        trap_tval_i  = 32'h55;
        tick();
        trap_vld_i = 1'b0;
        n_cmp++; if (csr_mepc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL trap_mepc got %h want %h", csr_mepc_o, 32'h8000_0100); end
        rd(12'h342, r);
        n_cmp++; if (r !== 32'h8000_0007) begin n_fail++; $display("FAIL trap_mcause got %h want %h", r, 32'h8000_0007); end
        rd(12'h343, r);
        n_cmp++; if (r !== 32'h55) begin n_fail++; $display("FAIL trap_mtval got %h want %h", r, 32'h55); end
        n_cmp++; if (csr_mstatus_o !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus got %h want %h", csr_mstatus_o, 32'h1880); end
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        n_cmp++; if (csr_mstatus_o !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus got %h want %h", csr_mstatus_o, 32'h1888); end
        // a trap beats a same-cycle mepc write
        trap_vld_i = 1'b1;
        trap_pc_i  = 32'h0000_0200;
        wr(12'h341, 2'b00, 32'h0000_1234);
        trap_vld_i = 1'b0;
        n_cmp++; if (csr_mepc_o !== 32'h200) begin n_fail++; $display("FAIL trap_over_write got %h want %h", csr_mepc_o, 32'h200); end
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    task automatic test_vectored();
        wr(12'h305, 2'b00, 32'h0000_1001);
        n_cmp++; if (csr_mtvec_o !== 32'h1001) begin n_fail++; $display("FAIL mtvec_value got %h want %h", csr_mtvec_o, 32'h1001); end
        trap_cause_i = 32'h8000_000B;
        #1;
        n_cmp++; if (trap_target_o !== 32'h102C) begin n_fail++; $display("FAIL vec_target_irq got %h want %h", trap_target_o, 32'h102C); end
        trap_cause_i = 32'h0000_0002;
        #1;
        n_cmp++; if (trap_target_o !== 32'h1000) begin n_fail++; $display("FAIL vec_target_exc got %h want %h", trap_target_o, 32'h1000); end
    endtask

    task automatic test_irq_priority();
        wr(12'h304, 2'b00, 32'hFFFF_FFFF);
        rd(12'h304, r);
        n_cmp++; if (r !== 32'h000F_0888) begin n_fail++; $display("FAIL mie_mask got %h want %h", r, 32'h000F_0888); end
        wr(12'h304, 2'b00, 32'h0001_0888);
        irq_tmr_i   = 1'b1;
        irq_ext_i   = 1'b1;
        irq_local_i = 4'b0001;
        #1;
        n_cmp++; if (irq_req_o !== 1'b0) begin n_fail++; $display("FAIL irq_latch_delay got %b want 0", irq_req_o); end
        tick();
        n_cmp++; if (irq_cause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL irq_local_wins got %h want %h", irq_cause_o, 32'h8000_0010); end
        irq_local_i = 4'b0000;
        tick();
        n_cmp++; if (irq_cause_o !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_ext_wins got %h want %h", irq_cause_o, 32'h8000_000B); end
        rd(12'h344, r);
        n_cmp++; if (r !== 32'h0000_0880) begin n_fail++; $display("FAIL mip_read got %h want %h", r, 32'h880); end
        wr(12'h300, 2'b10, 32'h0000_0008);
        n_cmp++; if (irq_req_o !== 1'b0 || irq_cause_o !== 32'h0) begin n_fail++; $display("FAIL irq_mie_off got %b/%h want 0/0", irq_req_o, irq_cause_o); end
        irq_ext_i = 1'b0;
        irq_sw_i  = 1'b1;
        wr(12'h300, 2'b01, 32'h0000_0008);
        n_cmp++; if (irq_cause_o !== 32'h8000_0003) begin n_fail++; $display("FAIL irq_sw_over_tmr got %h want %h", irq_cause_o, 32'h8000_0003); end
        irq_sw_i  = 1'b0;
        irq_tmr_i = 1'b0;
        tick();
    endtask

    task automatic test_counters();
        wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b00, 32'h0000_00FF);
        rd(12'hB00, r);
        n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_low_hold got %h want %h", r, 32'hFFFF_FFFF); end
        rd(12'hB80, r);
        n_cmp++; if (r !== 32'hFF) begin n_fail++; $display("FAIL mcycleh_write got %h want %h", r, 32'hFF); end
        tick();
        rd(12'hB00, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap got %h want 0", r); end
        rd(12'hB80, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mcycleh_wrap got %h want 0", r); end
        wr(12'h320, 2'b01, 32'h0000_0001);
        rd(12'hB00, held);
        tick();
        tick();
        tick();
        rd(12'hC00, r);
        n_cmp++; if (r !== held) begin n_fail++; $display("FAIL mcycle_inhibit got %h want %h", r, held); end
        for (int k = 0; k < 3; k++) begin
            instr_retire_i = 1'b1;
            tick();
            instr_retire_i = 1'b0;
            tick();
        end
        rd(12'hB02, r);
        n_cmp++; if (r !== 32'h3) begin n_fail++; $display("FAIL minstret_count got %h want 3", r); end
        wr(12'h320, 2'b01, 32'h0000_0004);
        rd(12'h320, r);
        n_cmp++; if (r !== 32'h5) begin n_fail++; $display("FAIL mcountinhibit got %h want 5", r); end
        instr_retire_i = 1'b1;
        tick();
        instr_retire_i = 1'b0;
        rd(12'hC02, r);
        n_cmp++; if (r !== 32'h3) begin n_fail++; $display("FAIL minstret_inhibit got %h want 3", r); end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_trap_mret();
        test_vectored();
        test_irq_priority();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
